// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_pkg: shared state type and default sizes for the systolic skew feeder
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} feeder_state_t;
  localparam int REG_WIDTH_DEF = 16;
  localparam int MESH_N_DEF = 4;
endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage data+valid shift register with synchronous active-low clear
module skew_delay_line import systolic_pkg::*; #(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_WIDTH-1:0] data_i,
  input  logic                 valid_i,
  output logic [REG_WIDTH-1:0] data_o,
  output logic                 valid_o
);
  logic [DEPTH-1:0][REG_WIDTH-1:0] data_q;
  logic [DEPTH-1:0]                valid_q;
  // advance every stage each cycle; clear wipes the whole line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= data_i;
      valid_q[0] <= valid_i;
      for (int s = 1; s < DEPTH; s++) begin
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end
  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: diagonal-skew edge feeder for the PE mesh; SKEW_FEEDER_BUBBLE_CNT_EN adds bubble_cnt
module systolic_skew_feeder import systolic_pkg::*; #(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int N = MESH_N_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*REG_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [REG_WIDTH-1:0]   edge_data [N-1:0],
  output logic [N-1:0]           edge_valid,
  output logic                   busy,
  output logic                   done
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
  ,
  output logic [15:0]            bubble_cnt
`endif
);
  localparam int CW = $clog2(N);
  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  assign accept = in_valid && in_ready;
  // state and flush counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: a last beat starts an N-cycle flush so lane N-1 drains completely
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, STREAM: begin
        state_d = accept ? (in_last ? FLUSH : STREAM) : state_q;
        cnt_d   = accept ? CW'(N-1) : cnt_q;
      end
      FLUSH: begin
        state_d = (cnt_q == '0) ? IDLE : FLUSH;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // handshake and status outputs; nothing is accepted while in reset
  always_comb begin
    in_ready = rst_n && (state_q != FLUSH);
    busy     = state_q != IDLE;
    done     = rst_n && (state_q == FLUSH) && (cnt_q == '0);
  end
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.REG_WIDTH(REG_WIDTH), .DEPTH(i+1)) u_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (accept ? in_data[i*REG_WIDTH +: REG_WIDTH] : '0),
      .valid_i (accept),
      .data_o  (edge_data[i]),
      .valid_o (edge_valid[i])
    );
  end
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  // count beatless STREAM cycles, saturating, restarting with each tile
  always_comb begin
    bubble_cnt_d = (state_q == IDLE && accept) ? '0 :
                   (state_q == STREAM && !in_valid && bubble_cnt_q != 16'hFFFF) ? bubble_cnt_q + 16'd1 :
                   bubble_cnt_q;
  end
  // bubble counter register
  always_ff @(posedge clk) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else bubble_cnt_q <= bubble_cnt_d;
  end
  assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: vector table, corner sequences and random traffic against a history model
module tb_systolic_skew_feeder;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0;
  logic in_ready, busy, done;
  logic [N*W-1:0] in_data = '0;
  logic [W-1:0] edge_data [N-1:0];
  logic [N-1:0] edge_valid;
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif
  always #5 clk = ~clk;
  systolic_skew_feeder #(.REG_WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .edge_data(edge_data),
    .edge_valid(edge_valid), .busy(busy), .done(done)
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );
  int nvec = 0, nerr = 0;
  int k = -1, last_edge = -100, bub = 0;
  bit streaming = 0;
  bit [N*W-1:0] hd [0:4095];
  bit hv [0:4095];
  typedef struct {
    bit rn, v, l;
    logic [63:0] d;
    logic [3:0] ev;
    logic [63:0] ed;
    bit dn, rdy;
  } vec_t;
  vec_t tbl [20];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // one clock: drive, check in_ready, clock, update model (hist index = edge number), check outputs
  task automatic cyc(input bit rn, input bit v, input bit l, input logic [N*W-1:0] d);
    bit acc;
    rst_n = rn; in_valid = v; in_last = l; in_data = d;
    #1;
    chk("in_ready", in_ready, rn && (k - last_edge >= N));
    acc = rn && v && (k - last_edge >= N);
    @(posedge clk); #1;
    k++;
    if (!rn) begin
      for (int j = 0; j < N; j++) if (k - j >= 0) begin hv[k-j] = 0; hd[k-j] = '0; end
      last_edge = -100; streaming = 0; bub = 0;
    end else begin
      hv[k] = acc;
      hd[k] = acc ? d : '0;
      if (streaming && !v && bub < 65535) bub++;
      if (acc) begin
        if (!streaming) bub = 0;
        streaming = !l;
        if (l) last_edge = k;
      end
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("lane%0d_valid", i), edge_valid[i], (k - i >= 0) ? hv[k-i] : 1'b0);
      chk($sformatf("lane%0d_data", i), edge_data[i], (k - i >= 0) ? hd[k-i][i*W +: W] : '0);
    end
    chk("done", done, k - last_edge == N - 1);
    chk("busy", busy, streaming || (k - last_edge < N));
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    chk("bubble_cnt", bubble_cnt, bub);
`endif
  endtask
  initial begin
    tbl[0]  = '{0, 1, 0, 64'h0, 4'h0, 64'h0, 0, 0};
    tbl[1]  = '{0, 1, 1, 64'h0, 4'h0, 64'h0, 0, 0};
    tbl[2]  = '{0, 1, 0, 64'h0, 4'h0, 64'h0, 0, 0};
    tbl[3]  = '{1, 1, 1, 64'h0004_0003_0002_0001, 4'h1, 64'h0000_0000_0000_0001, 0, 0};
    tbl[4]  = '{1, 0, 0, 64'h0, 4'h2, 64'h0000_0000_0002_0000, 0, 0};
    tbl[5]  = '{1, 0, 0, 64'h0, 4'h4, 64'h0000_0003_0000_0000, 0, 0};
    tbl[6]  = '{1, 0, 0, 64'h0, 4'h8, 64'h0004_0000_0000_0000, 1, 0};
    tbl[7]  = '{1, 0, 0, 64'h0, 4'h0, 64'h0, 0, 1};
    tbl[8]  = '{1, 1, 0, 64'h0013_0012_0011_0010, 4'h1, 64'h0000_0000_0000_0010, 0, 1};
    tbl[9]  = '{1, 1, 0, 64'h0023_0022_0021_0020, 4'h3, 64'h0000_0000_0011_0020, 0, 1};
    tbl[10] = '{1, 1, 1, 64'h0033_0032_0031_0030, 4'h7, 64'h0000_0012_0021_0030, 0, 0};
    tbl[11] = '{1, 0, 0, 64'h0, 4'hE, 64'h0013_0022_0031_0000, 0, 0};
    tbl[12] = '{1, 0, 0, 64'h0, 4'hC, 64'h0023_0032_0000_0000, 0, 0};
    tbl[13] = '{1, 0, 0, 64'h0, 4'h8, 64'h0033_0000_0000_0000, 1, 0};
    tbl[14] = '{1, 1, 1, 64'h0104_0103_0102_0101, 4'h0, 64'h0, 0, 1};
    tbl[15] = '{1, 1, 1, 64'h0104_0103_0102_0101, 4'h1, 64'h0000_0000_0000_0101, 0, 0};
    tbl[16] = '{1, 0, 0, 64'h0, 4'h2, 64'h0000_0000_0102_0000, 0, 0};
    tbl[17] = '{1, 0, 0, 64'h0, 4'h4, 64'h0000_0103_0000_0000, 0, 0};
    tbl[18] = '{1, 0, 0, 64'h0, 4'h8, 64'h0104_0000_0000_0000, 1, 0};
    tbl[19] = '{1, 0, 0, 64'h0, 4'h0, 64'h0, 0, 1};
    for (int r = 0; r < 3; r++) tbl[r].d = {$urandom, $urandom};
    for (int r = 0; r < 20; r++) begin
      cyc(tbl[r].rn, tbl[r].v, tbl[r].l, tbl[r].d);
      chk($sformatf("tbl%0d_valid", r), edge_valid, tbl[r].ev);
      chk($sformatf("tbl%0d_data", r), {edge_data[3], edge_data[2], edge_data[1], edge_data[0]}, tbl[r].ed);
      chk($sformatf("tbl%0d_done", r), done, tbl[r].dn);
      chk($sformatf("tbl%0d_ready", r), in_ready, tbl[r].rdy);
    end
    cyc(1, 1, 0, 64'h00A3_00A2_00A1_00A0);
    cyc(1, 0, 0, 64'h0);
    cyc(1, 0, 0, 64'h0);
    cyc(1, 1, 1, 64'h00B3_00B2_00B1_00B0);
    for (int r = 0; r < 5; r++) cyc(1, 0, 0, 64'h0);
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    chk("bubble_cnt_two", bubble_cnt, 16'd2);
`endif
    cyc(1, 1, 1, 64'h00C3_00C2_00C1_00C0);
    cyc(0, 0, 0, 64'h0);
    chk("midflush_rst_valid", edge_valid, 4'h0);
    chk("midflush_rst_done", done, 1'b0);
    cyc(1, 0, 0, 64'h0);
    chk("post_rst_ready", in_ready, 1'b1);
    for (int r = 0; r < 1500; r++)
      cyc($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(4) == 0, {$urandom, $urandom});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Edge feeder for the output-stationary PE mesh. Accepts one operand vector per cycle (N lanes) over a valid/ready handshake and drives the array's a or b edge.
- Applies diagonal skew: lane i is delayed by i cycles.
- Injects zero bubbles whenever no beat is available, because the mesh never stalls.
- Flushes the skew pipe after the last beat and pulses done. One instance is used per edge: a rows and b columns.

Parameters:
- REG_WIDTH, 16, width of one operand element.
- N, 4, number of lanes, equal to the mesh edge length (N >= 2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data/in_last hold a beat.
- in_ready  out  1  feeder can accept a beat this cycle.
- in_data  in  N*REG_WIDTH  lane i at bits [i*REG_WIDTH +: REG_WIDTH].
- in_last  in  1  marks the final beat of a tile.
- edge_data  out  REG_WIDTH x N (unpacked [N-1:0])  skewed operands to mesh edge.
- edge_valid  out  N  lane i carries a real (non-bubble) element.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the last element leaves lane N-1.

Behaviour:
- Reset (rst_n=0 at posedge), also mid-tile:
  - All delay stages, edge_data and edge_valid go to 0.
  - FSM goes to IDLE; done=0, busy=0; flush counter=0.
  - in_ready is 0 during the reset cycle.
- Handshake: a beat is accepted iff in_valid && in_ready at posedge. in_ready is combinational from state only: 1 in IDLE and STREAM, 0 in FLUSH. It never depends on in_valid.
- Skew pipe: lane i has a chain of i+1 registers.
  - Stage 0 loads in_data lane i with valid=1 on accept. Otherwise it loads 0 with valid=0 (bubble).
  - Lane i output is valid i+1 cycles after acceptance. Lane 0 latency is 1; lane N-1 latency is N.
  - Pipe advances every cycle, in every state, unconditionally.
- FSM:
  - IDLE -> STREAM on an accepted beat with in_last=0.
  - IDLE -> FLUSH on an accepted beat with in_last=1 (single-beat tile).
  - STREAM stays while beats arrive or bubbles are injected (in_valid=0 is legal, inject zeros). STREAM -> FLUSH on an accepted beat with in_last=1.
  - FLUSH loads cnt=N-1 on entry and decrements each cycle. Zeros are injected.
  - When cnt==0, done=1 for that cycle and next state is IDLE. The last beat's lane N-1 element is on edge_data[N-1] in the same cycle.
- Boundaries:
  - in_last seen in IDLE is handled as above.
  - A new tile is accepted in the cycle after done at the earliest.
  - in_valid high during FLUSH is ignored (not accepted) and must be held by the source.
  - No arithmetic; data is passed bit-exact with no width change.

Optional Feature:
- Macro SKEW_FEEDER_BUBBLE_CNT_EN.
- When defined:
  - Extra output bubble_cnt (16 bits) counts cycles in STREAM with in_valid=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset and on IDLE->STREAM/FLUSH entry.
  - Holds its value in IDLE.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package systolic_pkg:
  - feeder_state_t enum {IDLE, STREAM, FLUSH} (2-bit).
  - Default constants REG_WIDTH_DEF=16 and MESH_N_DEF=4.
- Sub-module skew_delay_line (params REG_WIDTH, DEPTH): DEPTH-stage data+valid shift register with synchronous active-low clear. It is instantiated N times with DEPTH=i+1.

Test Plan (N=4, REG_WIDTH=16):
- Reset check: hold rst_n=0 for 3 cycles with random in_data. Expect edge_data all 0, edge_valid=4'b0000, in_ready=0, busy=0, done=0.
- Single-beat tile: in_data={4,3,2,1}, in_last=1, accepted at cycle t. Expect:
  - edge_data[0]=1 valid at t+1; lane1=2 at t+2; lane2=3 at t+3; lane3=4 at t+4.
  - done=1 at t+4 only; in_ready=0 during t+1..t+4.
- Streaming 3 beats rows {0x10..13},{0x20..23},{0x30..33}, last on beat 3. Expect:
  - lane 3 emits 0x13, 0x23, 0x33 on consecutive cycles starting 4 cycles after beat 1.
  - done coincides with 0x33.
- Bubble injection: beat A, in_valid=0 for 2 cycles, beat B (last). Expect:
  - two zero/valid=0 slots between A and B on every lane.
  - bubble_cnt=2 with SKEW_FEEDER_BUBBLE_CNT_EN defined.
- Reset mid-FLUSH: assert rst_n=0 one cycle after the last beat is accepted. Expect:
  - next cycle all edge_valid=0 and no done pulse.
  - in_ready=1 the cycle after rst_n returns high.
- Back-to-back tiles: assert a new beat with in_valid=1 in the done cycle. Expect it is not accepted that cycle and is accepted the next cycle, with no overlap of tile data on any lane.
